// File: rtl/access_pkg.sv
// Shared types and constants for the access arbiter.
// Lease timeout hardware is enabled by defining LEASE_TIMEOUT_EN.
package access_pkg;
   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      GRANT,
      DENY
   } state_e;

   localparam int RES_W    = 4;
   localparam int MAP_MULT = 3;
   localparam int MAP_MOD  = 10;
   localparam int LEASE_W  = 8;
endpackage

// File: rtl/access_arbiter_resource_map.sv
// User ID to resource ID mapping: (user * MAP_MULT) mod MOD.
// Purely combinational; product is kept ID_W+2 bits wide.
module resource_map
   import access_pkg::*;
#(
   parameter int ID_W = 4,
   parameter int MOD  = MAP_MOD
) (
   input  logic [ID_W-1:0]  user_id,
   output logic [RES_W-1:0] res_id
);
   localparam int PROD_W = ID_W + 2;

   logic [PROD_W-1:0] prod;

   assign prod   = PROD_W'(user_id) * PROD_W'(MAP_MULT);
   assign res_id = RES_W'(prod % PROD_W'(MOD));
endmodule

// File: rtl/access_arbiter.sv
// Round-robin access arbiter owning the resource busy map.
// Define LEASE_TIMEOUT_EN to auto-expire leases after LEASE_CYCLES.
module access_arbiter
   import access_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ID_W         = 4,
   parameter int NUM_RES      = MAP_MOD,
   parameter int LEASE_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ID_W-1:0]    req_user,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       grant_valid,
   input  logic                       grant_ready,
   output logic [$clog2(NUM_REQ)-1:0] grant_req,
   output logic [RES_W-1:0]           grant_res,
   output logic                       deny_valid,
   output logic [$clog2(NUM_REQ)-1:0] deny_req,
   output logic [RES_W-1:0]           deny_res,
   input  logic                       release_valid,
   input  logic [RES_W-1:0]           release_res,
   output logic [NUM_RES-1:0]         busy_map
);
   localparam int IDX_W = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   rr_q, rr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ID_W-1:0]    user_q, user_d;
   logic [RES_W-1:0]   res_q, res_d;
   logic [NUM_RES-1:0] busy_q, busy_d;
`ifdef LEASE_TIMEOUT_EN
   logic [NUM_RES-1:0][LEASE_W-1:0] cnt_q, cnt_d;
`endif

   logic [RES_W-1:0]   map_res;
   logic               found;
   logic [IDX_W-1:0]   sel;
   logic [IDX_W-1:0]   cand;
   logic [ID_W-1:0]    sel_user;
   logic               rel_ok;
   logic               eff_busy;
   logic               hs;
   logic [IDX_W-1:0]   idx_next;
   logic [NUM_REQ-1:0] ready_c;

   resource_map #(
      .ID_W (ID_W),
      .MOD  (NUM_RES)
   ) u_map (
      .user_id (user_q),
      .res_id  (map_res)
   );

   // Rotating priority scan starting at rr_q
   always_comb begin
      found    = 1'b0;
      sel      = '0;
      cand     = '0;
      sel_user = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IDX_W'(i)) sel_user = req_user[i*ID_W +: ID_W];
      end
   end

   assign rel_ok   = release_valid && (int'(release_res) < NUM_RES);
   assign hs       = (state_q == GRANT) && grant_ready;
   assign idx_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   // A release landing in the lookup cycle makes the resource free
   always_comb begin
      eff_busy = 1'b0;
      for (int i = 0; i < NUM_RES; i++) begin
         if (map_res == RES_W'(i)) begin
            eff_busy = busy_q[i] &
                       ~(rel_ok && release_res == RES_W'(i));
         end
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      idx_d   = idx_q;
      user_d  = user_q;
      res_d   = res_q;
      ready_c = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               ready_c = NUM_REQ'(1) << sel;
               idx_d   = sel;
               user_d  = sel_user;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            res_d   = map_res;
            state_d = eff_busy ? DENY : GRANT;
         end
         GRANT: begin
            if (grant_ready) begin
               rr_d    = idx_next;
               state_d = IDLE;
            end
         end
         DENY: begin
            rr_d    = idx_next;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Expiry, then release, then grant set (set wins)
   always_comb begin
      busy_d = busy_q;
`ifdef LEASE_TIMEOUT_EN
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_RES; i++) begin
         if (busy_q[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
            if (cnt_q[i] == LEASE_W'(1)) busy_d[i] = 1'b0;
         end
      end
`endif
      for (int i = 0; i < NUM_RES; i++) begin
         if (rel_ok && release_res == RES_W'(i)) begin
            busy_d[i] = 1'b0;
`ifdef LEASE_TIMEOUT_EN
            cnt_d[i] = '0;
`endif
         end
         if (hs && res_q == RES_W'(i)) begin
            busy_d[i] = 1'b1;
`ifdef LEASE_TIMEOUT_EN
            cnt_d[i] = LEASE_W'(LEASE_CYCLES);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rr_q    <= '0;
         idx_q   <= '0;
         user_q  <= '0;
         res_q   <= '0;
         busy_q  <= '0;
`ifdef LEASE_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         idx_q   <= idx_d;
         user_q  <= user_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
`ifdef LEASE_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign req_ready   = rst ? '0 : ready_c;
   assign grant_valid = (state_q == GRANT);
   assign deny_valid  = (state_q == DENY);
   assign grant_req   = idx_q;
   assign grant_res   = res_q;
   assign deny_req    = idx_q;
   assign deny_res    = res_q;
   assign busy_map    = busy_q;
endmodule

// File: tb/tb_access_arbiter.sv
// Scoreboard bench for access_arbiter: expected grants/denies are
// queued by the stimulus and checked by an independent monitor.
module tb_access_arbiter;
   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_user;
   logic [3:0]  req_ready;
   logic        grant_valid;
   logic        grant_ready;
   logic [1:0]  grant_req;
   logic [3:0]  grant_res;
   logic        deny_valid;
   logic [1:0]  deny_req;
   logic [3:0]  deny_res;
   logic        release_valid;
   logic [3:0]  release_res;
   logic [9:0]  busy_map;

   int checks = 0;
   int passed = 0;

   // {is_grant, requester, resource}
   logic [6:0] exp_q[$];

   access_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_user      (req_user),
      .req_ready     (req_ready),
      .grant_valid   (grant_valid),
      .grant_ready   (grant_ready),
      .grant_req     (grant_req),
      .grant_res     (grant_res),
      .deny_valid    (deny_valid),
      .deny_req      (deny_req),
      .deny_res      (deny_res),
      .release_valid (release_valid),
      .release_res   (release_res),
      .busy_map      (busy_map)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops one expectation per grant handshake or deny pulse
   always @(negedge clk) begin
      if (!rst && grant_valid && grant_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected grant: req %0d res %0d",
                     grant_req, grant_res);
         end else begin
            chk("grant", {25'd0, 1'b1, grant_req, grant_res},
                {25'd0, exp_q.pop_front()});
         end
      end
      if (!rst && deny_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected deny: req %0d res %0d",
                     deny_req, deny_res);
         end else begin
            chk("deny", {25'd0, 1'b0, deny_req, deny_res},
                {25'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      step;
      rst = 1'b1;
      step;
      step;
      rst = 1'b0;
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         step;
         n++;
      end
      chk("drain", exp_q.size(), 0);
      step;
   endtask

   // Drive requests, dropping each bit once it has been accepted
   task automatic run_req(input logic [3:0] mask, input logic [15:0] users);
      int n;
      logic [3:0] acc;
      req_user  = users;
      req_valid = mask;
      n = 0;
      while (req_valid != 4'b0 && n < 40) begin
         @(negedge clk);
         acc = req_ready;
         step;
         req_valid = req_valid & ~acc;
         n++;
      end
      chk("all accepted", {28'd0, req_valid}, 0);
      drain;
   endtask

   task automatic pulse_release(input logic [3:0] r);
      release_valid = 1'b1;
      release_res   = r;
      step;
      release_valid = 1'b0;
      release_res   = 4'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      req_valid     = 4'b0;
      req_user      = 16'h0;
      grant_ready   = 1'b0;
      release_valid = 1'b0;
      release_res   = 4'd0;

      @(negedge clk);
      chk("reset outputs",
          {12'd0, req_ready, grant_valid, grant_req, grant_res,
           deny_valid, deny_req, deny_res}, 0);
      chk("reset busy", {22'd0, busy_map}, 0);
      step;
      rst = 1'b0;
      step;

      // User 7 -> resource 1, grant two cycles after acceptance
      req_user    = 16'h0007;
      req_valid   = 4'b0001;
      grant_ready = 1'b1;
      exp_q.push_back({1'b1, 2'd0, 4'd1});
      @(negedge clk);
      chk("t1 req_ready", {28'd0, req_ready}, 32'h1);
      step;
      req_valid = 4'b0;
      @(negedge clk);
      chk("t1 no grant in lookup", {31'd0, grant_valid}, 0);
      @(negedge clk);
      chk("t1 grant at T+2", {31'd0, grant_valid}, 1);
      @(negedge clk);
      chk("t1 busy", {22'd0, busy_map}, 32'h002);
      step;

      // All four request user 2 -> resource 6: one grant, three denies
      do_reset;
      exp_q.push_back({1'b1, 2'd0, 4'd6});
      exp_q.push_back({1'b0, 2'd1, 4'd6});
      exp_q.push_back({1'b0, 2'd2, 4'd6});
      exp_q.push_back({1'b0, 2'd3, 4'd6});
      run_req(4'b1111, 16'h2222);
      chk("t2 busy", {22'd0, busy_map}, 32'h040);

      // Users 5 and 15 collide on resource 5
      exp_q.push_back({1'b1, 2'd0, 4'd5});
      exp_q.push_back({1'b0, 2'd1, 4'd5});
      run_req(4'b0011, 16'h00F5);
      chk("t3 busy", {22'd0, busy_map}, 32'h060);

      // Same resource again, released during its lookup cycle
      exp_q.push_back({1'b1, 2'd2, 4'd5});
      req_user  = 16'h0500;
      req_valid = 4'b0100;
      @(negedge clk);
      chk("t3b req_ready", {28'd0, req_ready}, 32'h4);
      step;
      req_valid     = 4'b0;
      release_valid = 1'b1;
      release_res   = 4'd5;
      step;
      release_valid = 1'b0;
      release_res   = 4'd0;
      @(negedge clk);
      chk("t3b release seen", {22'd0, busy_map}, 32'h040);
      drain;
      chk("t3b busy", {22'd0, busy_map}, 32'h060);

      // Out-of-range and idle releases do nothing; valid one clears
      pulse_release(4'd12);
      step;
      chk("t6 release 12", {22'd0, busy_map}, 32'h060);
      pulse_release(4'd0);
      step;
      chk("t6 release idle", {22'd0, busy_map}, 32'h060);
      pulse_release(4'd6);
      step;
      chk("t6 release 6", {22'd0, busy_map}, 32'h020);

      // Backpressure: grant held stable, then reset mid-hold
      grant_ready = 1'b0;
      req_user    = 16'h9000;
      req_valid   = 4'b1000;
      @(negedge clk);
      chk("t4 req_ready", {28'd0, req_ready}, 32'h8);
      step;
      req_valid = 4'b0;
      step;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("t4 hold", {24'd0, grant_valid, grant_req, grant_res,
                         deny_valid},
             {24'd0, 1'b1, 2'd3, 4'd7, 1'b0});
      end
      step;
      req_valid = 4'b1111;
      rst       = 1'b1;
      #1;
      chk("t4 reset outputs",
          {12'd0, req_ready, grant_valid, grant_req, grant_res,
           deny_valid, deny_req, deny_res}, 0);
      chk("t4 reset busy", {22'd0, busy_map}, 0);
      step;
      req_valid   = 4'b0;
      rst         = 1'b0;
      grant_ready = 1'b1;
      step;

      // Lease: user 1 -> resource 3, watch it after the handshake
      exp_q.push_back({1'b1, 2'd0, 4'd3});
      req_user  = 16'h0001;
      req_valid = 4'b0001;
      @(negedge clk);
      step;
      req_valid = 4'b0;
      begin
         int n;
         n = 0;
         @(negedge clk);
         while (!(grant_valid && grant_ready) && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("t5 handshake seen", {31'd0, grant_valid}, 1);
      end
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k == 1) chk("t5 busy set", {22'd0, busy_map}, 32'h008);
         if (k == 16) chk("t5 busy before expiry", {31'd0, busy_map[3]}, 1);
         if (k == 17) begin
`ifdef LEASE_TIMEOUT_EN
            chk("t5 busy expired", {31'd0, busy_map[3]}, 0);
`else
            chk("t5 busy kept", {31'd0, busy_map[3]}, 1);
`endif
         end
      end

      step;
      chk("scoreboard empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/access_arbiter.md
# access_arbiter

Round-robin arbiter that shares the resource pool among several requesters. It accepts one requester at a time and maps the requester's user ID to a resource ID using the team's fixed mapping, resource = (user_id * 3) mod 10. It tracks which resources are leased, then either grants a free resource through a valid/ready handshake or denies a busy one. It sits between the user-facing request ports and the resource datapath and owns the resource busy map.

## Interface
- NUM_REQ, 4: number of requesters (2..16).
- ID_W, 4: user ID width.
- NUM_RES, 10: number of resources; also the mapping modulus.
- LEASE_CYCLES, 16: lease length, used only with the timeout macro (1..255).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request.
- req_user  in  NUM_REQ*ID_W  packed user IDs; requester i is in bits [i*ID_W +: ID_W].
- req_ready  out  NUM_REQ  one-hot acceptance strobe.
- grant_valid  out  1  grant offer.
- grant_ready  in  1  grant consumed.
- grant_req  out  clog2(NUM_REQ)  requester index being granted.
- grant_res  out  4  resource ID being granted.
- deny_valid  out  1  one-cycle deny pulse.
- deny_req  out  clog2(NUM_REQ)  denied requester index.
- deny_res  out  4  resource that was busy.
- release_valid  in  1  release strobe.
- release_res  in  4  resource being released.
- busy_map  out  NUM_RES  registered lease bitmap.

## Operation
- FSM states: IDLE, LOOKUP, GRANT, DENY.
- IDLE:
  - If any req_valid is set, select the first requester at or after rr_ptr, wrapping.
  - req_ready is combinational in IDLE: only the selected bit is high.
  - Capture the index and user ID, then go to LOOKUP.
  - If no req_valid is set, stay in IDLE.
- LOOKUP:
  - The resource is computed as (user*3) % 10 with a 6-bit product (maximum 45), giving a result in 0..9. Register it.
  - Check the effective busy bit. Effective busy = busy_map[res] & ~(release_valid & release_res==res), so a same-cycle release counts as free.
  - Free: go to GRANT. Busy: go to DENY.
- GRANT:
  - grant_valid=1. grant_req and grant_res stay stable until grant_ready.
  - On handshake: set busy_map[res], set rr_ptr=(idx+1) mod NUM_REQ, go to IDLE.
- DENY:
  - deny_valid=1 for exactly one cycle.
  - Advance rr_ptr as for a grant, then go to IDLE.
- Release:
  - Accepted in any state. Clears busy_map[release_res].
  - release_res >= NUM_RES is ignored.
  - Releasing a resource that is not busy has no effect.
- Grant handshake and a release of the same resource in the same cycle: the set wins.
- A requester that drops req_valid after acceptance still receives its grant or deny.

## Timing
- Reset values: every output is 0 (req_ready, grant_valid, grant_req, grant_res, deny_valid, deny_req, deny_res, busy_map). State is IDLE, rr_ptr is 0, and all lease counters are 0.
- Reset asserted mid-grant drops grant_valid immediately and clears all leases.
- Accept in cycle T; LOOKUP in T+1; grant_valid or deny_valid from T+2.
- busy_map updates on the edge ending the handshake cycle.
- Back-to-back throughput: one decision every 3 cycles when grant_ready is tied high.

## Configuration
- LEASE_TIMEOUT_EN defined:
  - Each resource has an 8-bit down-counter, loaded with LEASE_CYCLES on grant handshake.
  - When the counter reaches 0 while busy, the busy bit clears, so busy goes low exactly LEASE_CYCLES cycles after the handshake edge.
  - An explicit release clears both the busy bit and the counter.
- LEASE_TIMEOUT_EN undefined: no counters; only explicit release frees a resource.

## Structure
- Package access_pkg holds:
  - the state enum;
  - RES_W=4;
  - MAP_MULT=3;
  - MAP_MOD=10;
  - the LEASE_W=8 counter width.
- Sub-module resource_map: purely combinational user_id-to-resource_id mapping, instantiated once in LOOKUP.

## Test plan
- Reset release, req_valid=0001 with user 7 → req_ready=0001 at T, grant_valid at T+2 with grant_req=0 and grant_res=1; after grant_ready, busy_map=0x002.
- req_valid=1111 with all users 2 → grants/denies visit requesters in order 0,1,2,3. The first gets res 6; the rest are denied with deny_res=6.
- Users 5 and 15 both map to res 5 → second request is denied. With release_res=5 pulsed in its LOOKUP cycle, the second request is granted instead.
- grant_ready held low for 10 cycles → grant_valid, grant_req and grant_res stay stable; rst asserted mid-hold → every output is 0 in the same cycle.
- With LEASE_TIMEOUT_EN and LEASE_CYCLES=16: grant res 3, no release → busy_map[3] clears exactly 16 cycles after the handshake. Without the macro, bit 3 stays set.
- release_res=12 → ignored; busy_map unchanged.
